// File: rtl/pixel_streamer.sv
// pixel_streamer: replays a frame held in an internal byte-wide RAM as a
// raster-ordered pixel stream with optional inter-line blanking, a pause
// input, and end-of-line / end-of-frame markers.
module pixel_streamer #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int AW       = 12,
    parameter int LINE_GAP = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          pause,
    output logic [7:0]    pixel,
    output logic          pixel_valid,
    output logic          eol,
    output logic          eof,
    output logic          busy,
    output logic          frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW   = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? (LINE_GAP - 1) : 0);
    localparam logic [AW:0]   NPIX_W   = (AW + 1)'(NPIX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          done_q, done_d;
    logic          loaded_q, loaded_d;

    logic          accept;
    logic          issue;
    logic          last_x;
    logic          last_y;
    logic          wr_in_range;

    logic [7:0]    mem [0:(2**AW)-1];
    logic [7:0]    rd_q;

    // Block is open for writes/start only when idle and the frame_done
    // cycle has passed (busy still covers that cycle).
    assign accept      = (state_q == ST_IDLE) && !done_q;
    assign issue       = (state_q == ST_STREAM) && !pause;
    assign last_x      = (x_q == X_LAST);
    assign last_y      = (y_q == Y_LAST);
    assign wr_in_range = ({1'b0, wr_addr} < NPIX_W);

    // Frame RAM: gated write port and registered read on every issue.
    always_ff @(posedge clk) begin
        if (accept && wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_q <= mem[addr_q];
        end
    end

    // Next-state and output-register logic for the streaming FSM.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        gap_d    = gap_q;
        valid_d  = issue;
        eol_d    = issue && last_x;
        eof_d    = issue && last_x && last_y;
        done_d   = issue && last_x && last_y;
        loaded_d = loaded_q | issue;

        case (state_q)
            ST_IDLE: begin
                if (accept && start) begin
                    state_d = ST_STREAM;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    // Raster index advances linearly, so the address is a
                    // plain running counter.
                    addr_d = addr_q + AW'(1);
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            state_d = ST_IDLE;
                        end else begin
                            y_d = y_q + YW'(1);
                            if (LINE_GAP > 0) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_GAP: begin
                // Blanking runs for exactly LINE_GAP cycles; pause is ignored.
                if (gap_q == GAP_LAST) begin
                    state_d = ST_STREAM;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously (RAM excluded).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    // The read register has no reset; the loaded flag masks it to zero
    // until the first issue after reset, then pixel holds its last value.
    assign pixel       = loaded_q ? rd_q : 8'd0;
    assign pixel_valid = valid_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != ST_IDLE) || done_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Testbench for pixel_streamer: two instances (no blanking / 2-cycle
// blanking) share stimulus and are checked every cycle against a
// frame-index reference model, plus directed scenario checks.
module tb_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;

    logic [7:0] pix    [2];
    logic       val    [2];
    logic       eol_o  [2];
    logic       eof_o  [2];
    logic       busy_o [2];
    logic       done_o [2];

    pixel_streamer #(.IMG_W(W), .IMG_H(H), .AW(AW), .LINE_GAP(0)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .pause(pause),
        .pixel(pix[0]), .pixel_valid(val[0]), .eol(eol_o[0]), .eof(eof_o[0]),
        .busy(busy_o[0]), .frame_done(done_o[0])
    );

    pixel_streamer #(.IMG_W(W), .IMG_H(H), .AW(AW), .LINE_GAP(2)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .pause(pause),
        .pixel(pix[1]), .pixel_valid(val[1]), .eol(eol_o[1]), .eof(eof_o[1]),
        .busy(busy_o[1]), .frame_done(done_o[1])
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gap_of(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // ---------------- reference model ----------------
    // A frame is a walk over raster indices 0..N-1; a pixel is issued
    // whenever streaming, not blanking and not paused.
    int m_run [2];
    int m_idx [2];
    int m_gap [2];
    int m_valid [2];
    int m_pix [2];
    int m_eol [2];
    int m_eof [2];
    int m_done [2];
    int mm [2][N];

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    m_run[i] = 0; m_idx[i] = 0; m_gap[i] = 0;
                    m_valid[i] = 0; m_pix[i] = 0; m_eol[i] = 0;
                    m_eof[i] = 0; m_done[i] = 0;
                end else begin
                    int iss;
                    int acc;
                    iss = (m_run[i] != 0 && m_gap[i] == 0 && !pause) ? 1 : 0;
                    acc = (m_run[i] == 0 && m_done[i] == 0) ? 1 : 0;
                    m_valid[i] = iss;
                    m_eol[i]   = (iss != 0 && (m_idx[i] % W) == W - 1) ? 1 : 0;
                    m_eof[i]   = (iss != 0 && m_idx[i] == N - 1) ? 1 : 0;
                    m_done[i]  = m_eof[i];
                    if (iss != 0) m_pix[i] = mm[i][m_idx[i]];
                    if (acc != 0) begin
                        if (wr_en && int'(wr_addr) < N) mm[i][int'(wr_addr)] = int'(wr_data);
                        if (start) begin
                            m_run[i] = 1; m_idx[i] = 0; m_gap[i] = 0;
                        end
                    end else if (m_run[i] != 0) begin
                        if (m_gap[i] > 0) begin
                            m_gap[i]--;
                        end else if (iss != 0) begin
                            if (m_idx[i] == N - 1) begin
                                m_run[i] = 0;
                            end else begin
                                m_idx[i]++;
                                if (m_idx[i] % W == 0) m_gap[i] = gap_of(i);
                            end
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_valid", i), int'(val[i]), m_valid[i]);
            check($sformatf("u%0d_pixel", i), int'(pix[i]), m_pix[i]);
            check($sformatf("u%0d_eol", i), int'(eol_o[i]), m_eol[i]);
            check($sformatf("u%0d_eof", i), int'(eof_o[i]), m_eof[i]);
            check($sformatf("u%0d_done", i), int'(done_o[i]), m_done[i]);
            check($sformatf("u%0d_busy", i), int'(busy_o[i]),
                  (m_run[i] != 0 || m_done[i] != 0) ? 1 : 0);
        end
    end

    // Logs of valid output for the directed scenarios.
    int lp0[$];
    int lc0[$];
    int lp1[$];
    int lc1[$];
    int leol0[$];
    int ldone0 = 0;
    int bc0 = 0;

    initial forever begin
        @(negedge clk);
        if (val[0]) begin
            lp0.push_back(int'(pix[0]));
            lc0.push_back(cyc);
            if (eol_o[0]) leol0.push_back(int'(pix[0]));
            if (done_o[0]) ldone0++;
        end
        if (val[1]) begin
            lp1.push_back(int'(pix[1]));
            lc1.push_back(cyc);
        end
        if (busy_o[0]) bc0++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        lp0.delete(); lc0.delete(); lp1.delete(); lc1.delete();
        leol0.delete(); ldone0 = 0; bc0 = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_o[0] && !busy_o[1]) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic wait_pix(int v);
        int ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (val[0] && int'(pix[0]) == v) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        check($sformatf("reach_pixel_%0d", v), ok, 1);
    endtask

    task automatic check_seq(string name, int base_first);
        check({name, "_count"}, lp0.size(), N);
        for (int k = 0; k < N && k < lp0.size(); k++) begin
            if (k == 0) check({name, "_p0"}, lp0[k], base_first);
            else check($sformatf("%s_p%0d", name, k), lp0[k], k);
        end
    endtask

    int s_cyc;

    initial begin
        // Reset state
        tick(2);
        check("rst_valid", int'(val[0]), 0);
        check("rst_pixel", int'(pix[0]), 0);
        check("rst_busy", int'(busy_o[0]), 0);
        check("rst_done", int'(done_o[1]), 0);
        reset = 1'b1;
        tick(1);

        // Load frame: value = address; out-of-range addresses ignored.
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1;
            wr_addr = AW'(a);
            wr_data = (a < N) ? 8'(a) : 8'hEE;
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);

        // Plain frame
        clear_logs();
        s_cyc = cyc;
        pulse_start();
        wait_idle();
        tick(2);
        check_seq("frameA", 0);
        check("frameA_first_lat", (lc0.size() > 0) ? lc0[0] - s_cyc : -1, 2);
        check("frameA_span", (lc0.size() == N) ? lc0[N-1] - lc0[0] : -1, N - 1);
        check("frameA_eol_n", leol0.size(), 3);
        if (leol0.size() == 3) begin
            check("frameA_eol0", leol0[0], 3);
            check("frameA_eol1", leol0[1], 7);
            check("frameA_eol2", leol0[2], 11);
        end
        check("frameA_done_n", ldone0, 1);
        check("frameA_busy_cycles", bc0, N + 1);
        check("gap_count", lp1.size(), N);
        if (lc1.size() == N) begin
            check("gap_span", lc1[N-1] - lc1[0] + 1, 16);
            check("gap_burst1", lc1[4] - lc1[3], 3);
            check("gap_burst2", lc1[8] - lc1[7], 3);
            check("gap_inburst", lc1[3] - lc1[0], 3);
        end

        // Pause while pixel 5 would be issued
        clear_logs();
        pulse_start();
        wait_pix(4);
        pause = 1'b1;
        tick(1);
        check("pause_valid", int'(val[0]), 0);
        check("pause_hold", int'(pix[0]), 4);
        tick(2);
        pause = 1'b0;
        wait_idle();
        tick(2);
        check_seq("pauseF", 0);
        if (lc0.size() == N) check("pause_hole", lc0[5] - lc0[4], 4);

        // Mid-frame write and start are dropped
        clear_logs();
        pulse_start();
        tick(4);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hAA; start = 1'b1;
        tick(1);
        wr_en = 1'b0; start = 1'b0;
        wait_idle();
        tick(20);
        check_seq("midwr", 0);
        check("midwr_busy_cycles", bc0, N + 1);
        clear_logs();
        pulse_start();
        wait_idle();
        tick(2);
        check_seq("afterwr", 0);

        // Asynchronous reset at pixel 6
        clear_logs();
        pulse_start();
        wait_pix(6);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", int'(val[0]), 0);
        check("arst_busy", int'(busy_o[0]), 0);
        check("arst_pixel", int'(pix[0]), 0);
        check("arst_busy_u1", int'(busy_o[1]), 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("arst_no_done", ldone0, 0);
        clear_logs();
        pulse_start();
        wait_idle();
        tick(2);
        check_seq("replay", 0);

        // Write and start in the same cycle
        clear_logs();
        wr_en = 1'b1; wr_addr = AW'(11); wr_data = 8'h7F; start = 1'b1;
        tick(1);
        wr_en = 1'b0; start = 1'b0;
        wait_idle();
        tick(2);
        check("wrstart_last_u0", (lp0.size() == N) ? lp0[N-1] : -1, 127);
        check("wrstart_last_u1", (lp1.size() == N) ? lp1[N-1] : -1, 127);

        // Randomised traffic, checked every cycle by the model
        for (int k = 0; k < 3000; k++) begin
            pause   = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = AW'($urandom);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick(1);
        end
        pause = 1'b0; start = 1'b0; wr_en = 1'b0;
        wait_idle();
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
